seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Downstream display stage for the 8-register scrolling-message FSM. Consumes its 32-bit word of eight 4-bit character codes, takes a tear-free snapshot once per frame, and time-multiplexes the eight characters onto one shared active-low seven-segment bus. It inserts a blanking gap between digits to suppress ghosting and emits a frame pulse for downstream pacing.

## Interface
- DIV, 1000: clocks per digit slot; legal range 4 ≤ DIV ≤ 65535.
- BLANK, 50: clocks at the start of each slot with all anodes off; legal range 1 ≤ BLANK ≤ DIV-2.
- Clock  in  1  sole clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Q_in  in  32  character codes; nibble i (bits 4i+3:4i) is digit i, digit 7 is leftmost.
- An  out  8  active-low digit enables, at most one bit low.
- Seg  out  7  active-low segments, bit order gfedcba.
- Frame  out  1  one-clock pulse marking the start of each frame.

## Operation
- Internal state:
  - slot counter cnt, 0..DIV-1;
  - digit index d, 0..7;
  - 32-bit snapshot register.
- Each rising edge:
  - cnt increments;
  - at DIV-1, cnt wraps to 0 and d increments;
  - d wraps from 7 to 0.
- Snapshot update:
  - loads Q_in on every Reset cycle;
  - loads Q_in on the edge where cnt wraps and d goes 7→0 (the frame wrap);
  - holds its value otherwise, so Q_in changes mid-frame are invisible until the next frame.
- Per-slot phases, as a two-state machine per slot:
  - BLANK phase (cnt < BLANK): An = 8'hFF, Seg = 7'h7F;
  - DRIVE phase (cnt ≥ BLANK): An = ~(1<<d), Seg = glyph(snapshot nibble d).
- Glyph table, active-low output:
  - code 1 'H' → 7'h09;
  - code 2 'E' → 7'h06;
  - code 3 'L' → 7'h47;
  - code 4 'L' → 7'h47;
  - code 5 'O' → 7'h40;
  - codes 0 and 6–F are blank → 7'h7F, but An is still driven normally.
- Frame asserts for exactly one clock, on the cycle immediately after each frame-wrap edge. It does not assert after reset release.
- Reset values, taking effect on the first edge with Reset high:
  - cnt = 0, d = 0;
  - An = 8'hFF, Seg = 7'h7F, Frame = 0;
  - snapshot = Q_in.
- Reset asserted mid-slot or mid-frame aborts immediately; nothing is retained except the snapshot reload.

## Timing
- All outputs are registered and lag the cnt/d state they decode by exactly one clock.
- Edge numbering: edge 1 is the first rising edge with Reset low.
- After Reset deasserts:
  - An stays 8'hFF through edges 1..BLANK;
  - An = 8'hFE from edge BLANK+1 through edge DIV;
  - An returns to 8'hFF at edge DIV+1 for the next digit's BLANK phase.
- Drive window per digit: DIV-BLANK clocks. Blank window: BLANK clocks.
- Frame period is 8·DIV clocks. The first Frame pulse is high after edge 8·DIV and low again after edge 8·DIV+1.
- Snapshot-to-display latency: a word captured at the frame wrap first appears on Seg BLANK+1 edges later, on digit 0.
- Invariants, every cycle:
  - popcount(~An) ≤ 1;
  - An = 8'hFF whenever the decoded cnt < BLANK.
- No combinational path from Q_in to any output.

## Test plan
- Parameters for all scenarios: DIV=8, BLANK=2.
1. Basic scan: Q_in=32'h12345000, Reset 2 cycles then released.
   - Digits 0–2 show An=FE/FD/FB with Seg=7F.
   - Digits 3–7 show An=F7/EF/DF/BF/7F with Seg=40/47/47/06/09.
   - Each digit drives 6 clocks, preceded by 2 blank clocks.
2. Snapshot stability: after release, change Q_in to 32'h55555555 at edge 20.
   - Digits keep the old pattern through edge 64.
   - After the Frame pulse, all digits show Seg=7'h40.
3. Frame pulse: run 300 clocks.
   - Frame is high exactly one clock every 64.
   - First pulse is seen right after edge 64.
   - Never two consecutive high cycles.
4. Reset mid-operation: assert Reset during digit 3's DRIVE phase, with Q_in=32'h00000001.
   - Next edge: An=FF, Seg=7F, Frame=0.
   - After release: An=FE with Seg=09 appears at edge 3.
5. Blank codes: Q_in=32'hFEDC9860.
   - All eight anodes still scan in order.
   - Seg=7F in every DRIVE phase.
6. Invariant sweep: 2000 clocks of random Q_in with random single-cycle Reset pulses.
   - Check every cycle that at most one An bit is low.
   - Check An=FF in every decoded BLANK phase.
   - Check Seg=7F whenever An=FF.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes eight 4-bit character codes onto one shared active-low
//   seven-segment bus. A snapshot of Q_in is taken once per frame so that
//   mid-frame changes never tear the display. Each digit slot opens with a
//   blanking gap (all anodes off) to suppress ghosting, then drives its digit.
//
// Parameters
//   DIV    clocks per digit slot      (4 <= DIV <= 65535)
//   BLANK  blank clocks at slot start (1 <= BLANK <= DIV-2)
//
// Ports
//   Clock  in   1  sole clock, rising edge
//   Reset  in   1  synchronous, active-high
//   Q_in   in  32  character codes, nibble i is digit i (digit 7 leftmost)
//   An     out  8  active-low digit enables, at most one low
//   Seg    out  7  active-low segments, gfedcba
//   Frame  out  1  one-clock pulse after each frame wrap
module seg7_scan_driver #(
  parameter int DIV   = 1000,
  parameter int BLANK = 50
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Q_in,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  phase_t         phase;
  phase_t         phase_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     d;
  logic [31:0]    snap;
  logic           slot_end;
  logic           frame_wrap;
  logic [3:0]     code;
  logic [7:0]     an_next;
  logic [6:0]     seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h1:    glyph = 7'h09;
      4'h2:    glyph = 7'h06;
      4'h3:    glyph = 7'h47;
      4'h4:    glyph = 7'h47;
      4'h5:    glyph = 7'h40;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign slot_end   = (cnt == CW'(DIV - 1));
  assign frame_wrap = slot_end && (d == 3'd7);
  assign code       = snap[{d, 2'b00} +: 4];

  // The phase register always agrees with cnt < BLANK: it enters DRIVE on
  // the edge where cnt reaches BLANK and falls back to BLANK on the slot wrap.
  always_comb begin
    phase_next = phase;
    if (slot_end) begin
      phase_next = PH_BLANK;
    end else if (cnt == CW'(BLANK - 1)) begin
      phase_next = PH_DRIVE;
    end
  end

  // Outputs decode the current cnt/d/snapshot and are registered, so they
  // lag the scan state by one clock.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    if (phase == PH_DRIVE) begin
      an_next  = ~(8'b0000_0001 << d);
      seg_next = glyph(code);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt   <= '0;
      d     <= 3'd0;
      snap  <= Q_in;
      phase <= PH_BLANK;
      An    <= 8'hFF;
      Seg   <= 7'h7F;
      Frame <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        d <= d + 3'd1;
      end
      if (frame_wrap) begin
        snap <= Q_in;
      end
      phase <= phase_next;
      An    <= an_next;
      Seg   <= seg_next;
      Frame <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver with DIV=8, BLANK=2. Each driven
//   cycle pushes the outputs predicted by a position-based model of the
//   scan; the entry is popped and compared after the following rising edge.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Q_in  = 32'h0;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Frame;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame;
    logic       blank;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          pos   = 0;
  int          edge_no = 0;
  logic [31:0] m_snap = 32'h0;

  seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Q_in  (Q_in),
    .An    (An),
    .Seg   (Seg),
    .Frame (Frame)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    logic [6:0] r;
    r = 7'h7F;
    if (c == 4'h1) r = 7'h09;
    if (c == 4'h2) r = 7'h06;
    if (c == 4'h3 || c == 4'h4) r = 7'h47;
    if (c == 4'h5) r = 7'h40;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t edge=%0d: got %h want %h",
               tag, $time, edge_no, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, predict, then compare
  // shortly after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] q);
    exp_t e;
    int   slot;
    int   dig;
    @(negedge Clock);
    Reset = rst;
    Q_in  = q;
    if (rst) begin
      e      = '{an: 8'hFF, seg: 7'h7F, frame: 1'b0, blank: 1'b1};
      m_snap = q;
      pos    = 0;
      edge_no = 0;
    end else begin
      slot = pos % DIV;
      dig  = (pos / DIV) % 8;
      e.blank = (slot < BLANK);
      e.an    = e.blank ? 8'hFF : ~(8'h01 << dig);
      e.seg   = e.blank ? 7'h7F : ref_glyph(m_snap[dig*4 +: 4]);
      e.frame = (slot == DIV - 1) && (dig == 7);
      if (e.frame) m_snap = q;
      pos = (pos + 1) % (8 * DIV);
      edge_no++;
    end
    sb.push_back(e);
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("an", {24'h0, An}, {24'h0, e.an});
      checkOutput("seg", {25'h0, Seg}, {25'h0, e.seg});
      checkOutput("frame", {31'h0, Frame}, {31'h0, e.frame});
      checkOutput("onehot", {31'h0, ($countones(~An) <= 1)}, 32'd1);
      if (e.blank) checkOutput("blank_an", {24'h0, An}, 32'h0000_00FF);
      if (An == 8'hFF) checkOutput("dark_seg", {25'h0, Seg}, 32'h0000_007F);
    end
  endtask

  initial begin
    int first_frame;
    int frame_cnt;
    int consec;
    logic prev;

    // Basic scan
    applyStimulus(1'b1, 32'h1234_5000);
    checkOutput("rst_an", {24'h0, An}, 32'hFF);
    checkOutput("rst_seg", {25'h0, Seg}, 32'h7F);
    checkOutput("rst_frame", {31'h0, Frame}, 32'd0);
    applyStimulus(1'b1, 32'h1234_5000);
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b0, 32'h1234_5000);
      if (i == BLANK)   checkOutput("edge_blank_an", {24'h0, An}, 32'hFF);
      if (i == BLANK+1) checkOutput("edge_first_an", {24'h0, An}, 32'hFE);
      if (i == DIV)     checkOutput("edge_div_an", {24'h0, An}, 32'hFE);
      if (i == DIV+1)   checkOutput("edge_next_an", {24'h0, An}, 32'hFF);
      if (i == 28)      checkOutput("d3_seg", {25'h0, Seg}, 32'h40);
      if (i == 60)      checkOutput("d7_seg", {25'h0, Seg}, 32'h09);
    end

    // Snapshot stability
    applyStimulus(1'b1, 32'h1234_5000);
    for (int i = 1; i <= 80; i++) begin
      applyStimulus(1'b0, (i >= 20) ? 32'h5555_5555 : 32'h1234_5000);
      if (i == 59) checkOutput("old_d7_seg", {25'h0, Seg}, 32'h09);
      if (i == 67) checkOutput("new_d0_seg", {25'h0, Seg}, 32'h40);
      if (i == 75) checkOutput("new_d1_seg", {25'h0, Seg}, 32'h40);
    end

    // Frame pulse spacing
    applyStimulus(1'b1, 32'h0000_0123);
    first_frame = 0;
    frame_cnt   = 0;
    consec      = 0;
    prev        = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b0, 32'h0000_0123);
      if (Frame) begin
        if (first_frame == 0) first_frame = edge_no;
        frame_cnt++;
        if (prev) consec++;
      end
      prev = Frame;
    end
    checkOutput("frame_first", first_frame, 32'd64);
    checkOutput("frame_count", frame_cnt, 32'd4);
    checkOutput("frame_consec", consec, 32'd0);

    // Reset during digit 3 drive
    applyStimulus(1'b1, 32'h1234_5000);
    for (int i = 1; i <= 28; i++) applyStimulus(1'b0, 32'h1234_5000);
    checkOutput("pre_rst_an", {24'h0, An}, 32'hF7);
    applyStimulus(1'b1, 32'h0000_0001);
    checkOutput("mid_rst_an", {24'h0, An}, 32'hFF);
    checkOutput("mid_rst_seg", {25'h0, Seg}, 32'h7F);
    checkOutput("mid_rst_frame", {31'h0, Frame}, 32'd0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 32'h0000_0001);
    checkOutput("post_rst_an", {24'h0, An}, 32'hFE);
    checkOutput("post_rst_seg", {25'h0, Seg}, 32'h09);

    // Blank codes still scan anodes
    applyStimulus(1'b1, 32'hFEDC_9860);
    for (int i = 1; i <= 64; i++) applyStimulus(1'b0, 32'hFEDC_9860);

    // Random sweep with occasional reset pulses
    applyStimulus(1'b1, $urandom);
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
